// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encodings, digit indices and BCD limits for the clock sequencer
package clock_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      SET_SEC = 2'd3
   } mode_t;

   localparam int IDX_SL = 0;
   localparam int IDX_SH = 1;
   localparam int IDX_ML = 2;
   localparam int IDX_MH = 3;
   localparam int IDX_HL = 4;
   localparam int IDX_HH = 5;

   localparam logic [3:0] DEC_MAX    = 4'd9;
   localparam logic [3:0] SEX_MAX    = 4'd5;
   localparam logic [3:0] HR_HI_MAX  = 4'd2;
   localparam logic [3:0] HR_LO_WRAP = 4'd3;

   function automatic mode_t next_mode(input mode_t m);
      return (m == RUN) ? SET_HR : (m == SET_HR) ? SET_MIN : (m == SET_MIN) ? SET_SEC : RUN;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider producing a one-cycle tick every TICK_DIV clocks
module tick_prescaler #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic Clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt;

   // count 0..TICK_DIV-1; tick is registered one step early so it is high while cnt sits at the terminal value
   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
         tick <= cnt == CW'(TICK_DIV - 2);
      end
   end

endmodule

// File: rtl/clock_seq_ctrl.sv
// clock_seq_ctrl: mode FSM and ripple-carry strobe sequencer for the six BCD clock digits
module clock_seq_ctrl
   import clock_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic       Clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] d_sl,
   input  logic [3:0] d_sh,
   input  logic [3:0] d_ml,
   input  logic [3:0] d_mh,
   input  logic [3:0] d_hl,
   input  logic [3:0] d_hh,
   output logic [5:0] inc_en,
   output logic [5:0] clr,
   output logic [1:0] mode,
   output logic       blink,
   output logic       tick
);

   mode_t      st;
   mode_t      mode_nx;
   logic       run_adv;
   logic       btn_ok;
   logic       c_sh;
   logic       c_ml;
   logic       m_step;
   logic       c_mh;
   logic       m_wrap;
   logic       h_step;
   logic       h_wrap;
   logic       h_carry;
   logic       sec_clr;
   logic [5:0] inc_d;
   logic [5:0] clr_d;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .Clk (Clk),
      .rst (rst),
      .tick(tick)
   );

   assign mode = st;

   // carry decode: RUN ticks ripple through all fields, SET buttons enter at the selected field only
   always_comb begin
      mode_nx = btn_mode ? next_mode(st) : st;
      run_adv = (st == RUN) && tick;
      btn_ok  = btn_inc && !btn_mode;
      sec_clr = (st == SET_SEC) && btn_ok;
      c_sh    = run_adv && (d_sl >= DEC_MAX);
      c_ml    = c_sh && (d_sh >= SEX_MAX);
      m_step  = c_ml || ((st == SET_MIN) && btn_ok);
      c_mh    = m_step && (d_ml >= DEC_MAX);
      m_wrap  = c_mh && (d_mh >= SEX_MAX);
      h_step  = (run_adv && m_wrap) || ((st == SET_HR) && btn_ok);
      h_wrap  = h_step && (d_hh >= HR_HI_MAX) && (d_hl >= HR_LO_WRAP);
      h_carry = h_step && !h_wrap && (d_hl >= DEC_MAX);
      inc_d[IDX_SL] = run_adv && !c_sh;
      clr_d[IDX_SL] = c_sh || sec_clr;
      inc_d[IDX_SH] = c_sh && !c_ml;
      clr_d[IDX_SH] = c_ml || sec_clr;
      inc_d[IDX_ML] = m_step && !c_mh;
      clr_d[IDX_ML] = c_mh;
      inc_d[IDX_MH] = c_mh && !m_wrap;
      clr_d[IDX_MH] = m_wrap;
      inc_d[IDX_HL] = h_step && !h_wrap && !h_carry;
      clr_d[IDX_HL] = h_wrap || h_carry;
      inc_d[IDX_HH] = h_carry;
      clr_d[IDX_HH] = h_wrap;
   end

   // mode FSM with registered strobes; blink toggles on ticks in SET modes and is forced low whenever RUN is entered
   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         st     <= RUN;
         inc_en <= '0;
         clr    <= '0;
         blink  <= 1'b0;
      end else begin
         st     <= mode_nx;
         inc_en <= inc_d;
         clr    <= clr_d;
         blink  <= (mode_nx == RUN) ? 1'b0 : blink ^ (tick && st != RUN);
      end
   end

endmodule

// File: tb/tb_clock_seq_ctrl.sv
// tb_clock_seq_ctrl: random and directed check of clock_seq_ctrl against a time-arithmetic model with an emulated counter bank
module tb_clock_seq_ctrl;

   localparam int TD = 4;

   logic       Clk = 1'b0;
   logic       rst;
   logic       btn_mode;
   logic       btn_inc;
   logic [3:0] d_sl, d_sh, d_ml, d_mh, d_hl, d_hh;
   logic [5:0] inc_en;
   logic [5:0] clr;
   logic [1:0] mode;
   logic       blink;
   logic       tick;

   int         checks = 0;
   int         errors = 0;
   int         dig[6];
   int         cyc = 0;
   int         mmode = 0;
   logic       mblink = 1'b0;
   logic [5:0] pi = '0;
   logic [5:0] pc = '0;

   clock_seq_ctrl #(.TICK_DIV(TD)) dut (
      .Clk     (Clk),
      .rst     (rst),
      .btn_mode(btn_mode),
      .btn_inc (btn_inc),
      .d_sl    (d_sl),
      .d_sh    (d_sh),
      .d_ml    (d_ml),
      .d_mh    (d_mh),
      .d_hl    (d_hl),
      .d_hh    (d_hh),
      .inc_en  (inc_en),
      .clr     (clr),
      .mode    (mode),
      .blink   (blink),
      .tick    (tick)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic drive_digits();
      d_sl = 4'(dig[0]);
      d_sh = 4'(dig[1]);
      d_ml = 4'(dig[2]);
      d_mh = 4'(dig[3]);
      d_hl = 4'(dig[4]);
      d_hh = 4'(dig[5]);
   endtask

   task automatic set_time(input int h, input int m, input int s);
      dig = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
      drive_digits();
   endtask

   // one clock: predict the next registered outputs from wall-clock arithmetic, advance, compare
   task automatic step(input logic bm, input logic bi);
      int n[6];
      int h, mi, s, t;
      logic tk;
      logic [5:0] ei, ec;
      logic [1:0] em;
      logic eb;
      btn_mode = bm;
      btn_inc  = bi;
      drive_digits();
      tk = (cyc % TD) == TD - 1;
      chk("tick", tick, tk);
      h  = dig[5] * 10 + dig[4];
      mi = dig[3] * 10 + dig[2];
      s  = dig[1] * 10 + dig[0];
      ei = '0;
      ec = '0;
      if (mmode == 0 && tk) begin
         t  = (h * 3600 + mi * 60 + s + 1) % 86400;
         h  = t / 3600;
         mi = (t / 60) % 60;
         s  = t % 60;
      end else if (bi && !bm && mmode == 1) h = (h + 1) % 24;
      else if (bi && !bm && mmode == 2) mi = (mi + 1) % 60;
      else if (bi && !bm && mmode == 3) ec = 6'b000011;
      n = '{s % 10, s / 10, mi % 10, mi / 10, h % 10, h / 10};
      for (int i = 0; i < 6; i++)
         if (n[i] != dig[i]) begin
            if (n[i] == 0) ec[i] = 1'b1;
            else ei[i] = 1'b1;
         end
      em = bm ? 2'((mmode + 1) % 4) : 2'(mmode);
      eb = (em == 2'd0) ? 1'b0 : (mblink ^ (tk && mmode != 0));
      @(posedge Clk);
      #1;
      cyc++;
      for (int i = 0; i < 6; i++) dig[i] = pc[i] ? 0 : pi[i] ? dig[i] + 1 : dig[i];
      chk("inc_en", inc_en, ei);
      chk("clr", clr, ec);
      chk("mode", mode, em);
      chk("blink", blink, eb);
      chk("inc_clr_overlap", inc_en & clr, 0);
      pi = inc_en;
      pc = clr;
      mmode = em;
      mblink = eb;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
   endtask

   task automatic to_tick();
      for (int k = 0; k < TD && (cyc % TD) != TD - 1; k++) step(1'b0, 1'b0);
   endtask

   initial begin
      int gap;
      logic bm, bi;
      rst = 1'b0;
      btn_mode = 1'b0;
      btn_inc = 1'b0;
      set_time(0, 0, 0);
      #12;
      chk("rst_inc", inc_en, 0);
      chk("rst_clr", clr, 0);
      chk("rst_mode", mode, 0);
      chk("rst_blink", blink, 0);
      chk("rst_tick", tick, 0);
      #10;
      rst = 1'b1;

      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("no_early_tick", tick, 0);
      step(1'b0, 1'b0);
      chk("first_tick_cycle4", tick, 1);
      step(1'b0, 1'b0);
      chk("first_inc", inc_en, 6'b000001);
      chk("first_clr", clr, 0);

      to_tick();
      set_time(12, 59, 59);
      step(1'b0, 1'b0);
      chk("1259_clr", clr, 6'b001111);
      chk("1259_inc", inc_en, 6'b010000);

      to_tick();
      set_time(23, 59, 59);
      step(1'b0, 1'b0);
      chk("2359_clr", clr, 6'b111111);
      chk("2359_inc", inc_en, 0);

      to_tick();
      set_time(9, 0, 0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      chk("mode_sethr", mode, 1);
      step(1'b1, 1'b1);
      chk("mode_setmin", mode, 2);
      chk("dropped_inc", inc_en, 0);
      chk("dropped_clr", clr, 0);

      set_time(9, 59, 0);
      step(1'b0, 1'b1);
      chk("min_wrap_clr", clr, 6'b001100);
      chk("min_wrap_inc", inc_en, 0);
      to_tick();
      step(1'b0, 1'b0);
      chk("setmin_tick_inc", inc_en, 0);
      chk("setmin_blink", blink, 1);

      step(1'b1, 1'b0);
      chk("mode_setsec", mode, 3);
      to_tick();
      set_time(0, 0, 37);
      step(1'b0, 1'b1);
      chk("sec_clr", clr, 6'b000011);
      chk("sec_inc", inc_en, 0);
      chk("sec_blink", blink, 0);

      #1;
      rst = 1'b0;
      #1;
      chk("arst_inc", inc_en, 0);
      chk("arst_clr", clr, 0);
      chk("arst_mode", mode, 0);
      chk("arst_blink", blink, 0);
      chk("arst_tick", tick, 0);
      #1;
      rst = 1'b1;
      cyc = 0;
      mmode = 0;
      mblink = 1'b0;
      pi = '0;
      pc = '0;

      gap = 3;
      repeat (3000) begin
         bm = 1'b0;
         bi = 1'b0;
         if (gap >= 3) begin
            bm = ($urandom % 16) == 0;
            bi = ($urandom % 4) == 0;
            if (bm || bi) gap = 0;
         end
         gap++;
         if (pi == 0 && pc == 0 && ($urandom % 40) == 0)
            set_time(int'($urandom % 24), int'($urandom % 60), int'($urandom % 60));
         step(bm, bi);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_seq_ctrl.md
# clock_seq_ctrl

Sequencing controller for the digital clock's six cascaded 4-bit BCD digit counters (sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi). It derives a 1 Hz tick from Clk and issues one-cycle increment and clear strobes per digit, so the counters hold 00:00:00–23:59:59. A mode FSM lets the user set hours and minutes and zero seconds from two pre-debounced buttons. Sits between the button conditioner and the digit counter bank; the counters' Dout values feed back as inputs.

## Interface
- TICK_DIV, 100_000_000: Clk cycles per tick (must be ≥4).
- Clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_mode  in  1  one-cycle pulse; advances mode.
- btn_inc  in  1  one-cycle pulse; increments the selected field.
- d_sl, d_sh, d_ml, d_mh, d_hl, d_hh  in  4 each  current digit counter values.
- inc_en  out  6  per-digit increment strobe; bit index 0..5 = sl, sh, ml, mh, hl, hh.
- clr  out  6  per-digit synchronous-clear strobe, same indexing.
- mode  out  2  0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.
- blink  out  1  display blink phase for the selected field.
- tick  out  1  one-cycle 1 Hz pulse.

## Operation
- Reset values: mode=RUN, inc_en=0, clr=0, blink=0, tick=0, prescaler=0.
- FSM: RUN→SET_HR→SET_MIN→SET_SEC→RUN on each btn_mode pulse.
- RUN, on tick, ripple carry:
  - inc sl, unless sl≥9: clr sl and carry to sh.
  - sh: inc, unless sh≥5: clr sh and carry to ml.
  - ml/mh follow the same rule (9 / 5).
  - Hours: if hh≥2 and hl≥3, clr hl and hh (23:59:59→00:00:00); else if hl≥9, clr hl and inc hh; else inc hl.
- Comparisons use ≥, so out-of-range digits wrap rather than overflow.
- SET_HR, on btn_inc: hours step +1 with the same 23→00 wrap. No carry into other fields.
- SET_MIN, on btn_inc: minutes step +1 with 59→00 wrap. No carry into hours.
- SET_SEC, on btn_inc: clr sl and sh.
- In all SET modes, tick does not advance time; it toggles blink. In RUN, blink is held at 0.
- btn_mode and btn_inc in the same cycle: mode change wins and btn_inc is dropped.
- btn_inc in RUN is ignored.
- Invariant: inc_en[i] and clr[i] are never both 1.

## Timing
- The prescaler counts 0..TICK_DIV-1. tick is high in the cycle where count = TICK_DIV-1.
- First tick occurs in cycle TICK_DIV after reset release.
- inc_en, clr and blink are registered and assert the cycle after the triggering tick or btn_inc.
- Counters update on the following edge, so digit inputs are settled ≥2 cycles before the next tick.
- mode updates the cycle after btn_mode.
- In SET modes, btn_inc coincident with tick: the increment is issued and blink still toggles.
- Reset asserted mid-operation clears all outputs immediately, asynchronously. Any pending strobe is lost.
- The prescaler runs in every mode and is never restarted except by rst.

## Structure
- Package clock_pkg holds:
  - mode encodings (RUN, SET_HR, SET_MIN, SET_SEC);
  - digit index constants (IDX_SL..IDX_HH);
  - limit constants (DEC_MAX=9, SEX_MAX=5, HR_HI_MAX=2, HR_LO_WRAP=3).
- One sub-module, tick_prescaler (parameter TICK_DIV; ports Clk, rst, tick), instantiated once.
- Carry decode is combinational from the digit inputs and the tick/btn qualifiers, then registered into inc_en/clr.

## Test plan
- Reset, TICK_DIV=4, digits 00:00:00 → first tick in cycle 4; inc_en=000001 and clr=0 the next cycle.
- RUN, digits 12:59:59, tick → next cycle clr=001111, inc_en=010000 (becomes 13:00:00).
- RUN, digits 23:59:59, tick → clr=111111, inc_en=0.
- Four btn_mode pulses → mode sequence 1,2,3,0. Same-cycle btn_inc in SET_HR with digits 09 → no strobe, mode=SET_MIN.
- SET_MIN, digits xx:59, btn_inc → clr=001100, hour bits 0. Tick during SET_MIN → no inc_en, blink toggles 0→1.
- SET_SEC, digits 00:00:37, btn_inc coincident with tick → clr=000011, blink toggles. rst pulsed mid-strobe → all outputs 0 the same cycle.
